hs_axis_stall_watchdog: RTL and testbench

Deadlock qualifier for the hyperspectral dataflow kernel's AXI-Stream stages. It samples the per-stage AXIS blocked and idle flags and the instance-block flag. A kernel block is declared only after every non-idle stage has been stuck for STALL_THRESH consecutive cycles. It also captures a sticky snapshot of the offending channels and episode statistics. It feeds the simulation-side block reporter and the debug status registers.

---
 rtl/hs_dbg_pkg.sv | 22 ++
 rtl/hs_sat_counter.sv | 29 ++
 rtl/hs_axis_stall_watchdog.sv | 135 +++++++++++++
 tb/tb_hs_axis_stall_watchdog.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_dbg_pkg.sv
// Shared types, default constants and helpers for the kernel debug monitors.
package hs_dbg_pkg;

  localparam int unsigned DEF_NUM_CH       = 4;
  localparam int unsigned DEF_STALL_THRESH = 1024;
  localparam int unsigned DEF_CNT_W        = 16;
  localparam int unsigned DEF_EVT_W        = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WATCH   = 2'd1,
    BLOCKED = 2'd2
  } wd_state_e;

  // Increment v, saturating at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/hs_sat_counter.sv
// Saturating counter with load, clear and increment; load has priority, then clear.
module hs_sat_counter
  import hs_dbg_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= W'(sat_inc(32'(count), W));
    end
  end

endmodule

// File: rtl/hs_axis_stall_watchdog.sv
// Deadlock qualifier: declares a kernel block after every non-idle stage has
// been stuck for STALL_THRESH consecutive cycles, with sticky episode status.
module hs_axis_stall_watchdog
  import hs_dbg_pkg::*;
#(
  parameter int unsigned NUM_CH       = DEF_NUM_CH,
  parameter int unsigned STALL_THRESH = DEF_STALL_THRESH,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned EVT_W        = DEF_EVT_W
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [NUM_CH-1:0] axis_block_sigs,
  input  logic [NUM_CH-1:0] inst_idle_sigs,
  input  logic              inst_block_sigs,
  output logic              block,
  output logic              block_pulse,
  output logic [NUM_CH-1:0] block_mask,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [EVT_W-1:0]  event_count
);

  localparam logic [CNT_W-1:0] THRESH_M1  = CNT_W'(STALL_THRESH - 1);
  localparam logic [CNT_W-1:0] THRESH_VAL = CNT_W'(STALL_THRESH);

  logic [NUM_CH-1:0] stuck_c;
  logic              quiet_c;
  logic              cand_c;

  wd_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              enter_c;
  logic              stall_inc_c;
  logic [EVT_W-1:0]  evt_load_c;

  // Qualification: a blocked-but-idle channel counts as idle.
  assign stuck_c = axis_block_sigs & ~inst_idle_sigs;
  assign quiet_c = &(stuck_c | inst_idle_sigs);
  assign cand_c  = enable & quiet_c & ((|stuck_c) | inst_block_sigs);

  // Next-state, qualification counter and episode strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    enter_c     = 1'b0;
    stall_inc_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (cand_c) begin
          state_d = WATCH;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      WATCH: begin
        if (!cand_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == THRESH_M1) begin
          state_d = BLOCKED;
          enter_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BLOCKED: begin
        if (!cand_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          stall_inc_c = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and qualification counter registers.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Block flag, entry strobe and sticky channel snapshot; entry beats clear.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      block       <= 1'b0;
      block_pulse <= 1'b0;
      block_mask  <= '0;
    end else begin
      block       <= (state_d == BLOCKED);
      block_pulse <= enter_c;
      if (enter_c) begin
        block_mask <= stuck_c;
      end else if (clear) begin
        block_mask <= '0;
      end
    end
  end

  // A clear coinciding with entry must still record this declaration as the first.
  assign evt_load_c = clear ? EVT_W'(1) : EVT_W'(sat_inc(32'(event_count), EVT_W));

  hs_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .clr      (clear),
    .load     (enter_c),
    .load_val (THRESH_VAL),
    .inc      (stall_inc_c),
    .count    (stall_cycles)
  );

  hs_sat_counter #(.W(EVT_W)) u_event_cnt (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .clr      (clear),
    .load     (enter_c),
    .load_val (evt_load_c),
    .inc      (1'b0),
    .count    (event_count)
  );

endmodule

// File: tb/tb_hs_axis_stall_watchdog.sv
// Directed bench for hs_axis_stall_watchdog with a run-length reference model.
module tb_hs_axis_stall_watchdog;

  localparam int THRESH  = 8;
  localparam int NCH     = 4;
  localparam int STL_MAX = 65535;
  localparam int EVT_MAX = 255;

  logic           ap_clk;
  logic           ap_rst_n;
  logic           enable;
  logic           clear;
  logic [NCH-1:0] axis_block_sigs;
  logic [NCH-1:0] inst_idle_sigs;
  logic           inst_block_sigs;
  logic           block;
  logic           block_pulse;
  logic [NCH-1:0] block_mask;
  logic [15:0]    stall_cycles;
  logic [7:0]     event_count;

  int checks = 0;
  int errors = 0;

  hs_axis_stall_watchdog #(
    .NUM_CH(NCH), .STALL_THRESH(THRESH), .CNT_W(16), .EVT_W(8)
  ) dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .enable          (enable),
    .clear           (clear),
    .axis_block_sigs (axis_block_sigs),
    .inst_idle_sigs  (inst_idle_sigs),
    .inst_block_sigs (inst_block_sigs),
    .block           (block),
    .block_pulse     (block_pulse),
    .block_mask      (block_mask),
    .stall_cycles    (stall_cycles),
    .event_count     (event_count)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Reference model: length of the current run of qualifying edges decides everything.
  int             run = 0;
  bit             m_valid = 1'b0;
  bit             m_block = 1'b0;
  bit             m_pulse = 1'b0;
  logic [NCH-1:0] m_mask = '0;
  int             m_stall = 0;
  int             m_evt = 0;
  logic [NCH-1:0] m_stuck;
  bit             m_cand;

  always @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      run = 0; m_block = 0; m_pulse = 0; m_mask = '0; m_stall = 0; m_evt = 0;
      m_valid = 1'b1;
    end else begin
      m_stuck = axis_block_sigs & ~inst_idle_sigs;
      m_cand  = enable && ((m_stuck | inst_idle_sigs) == {NCH{1'b1}}) &&
                ((m_stuck != '0) || inst_block_sigs);
      run     = m_cand ? run + 1 : 0;
      m_pulse = (run == THRESH);
      m_block = (run >= THRESH);
      if (run == THRESH) begin
        m_mask  = m_stuck;
        m_stall = THRESH;
        m_evt   = clear ? 1 : ((m_evt >= EVT_MAX) ? EVT_MAX : m_evt + 1);
      end else if (clear) begin
        m_mask = '0; m_stall = 0; m_evt = 0;
      end else if (run > THRESH) begin
        m_stall = (m_stall >= STL_MAX) ? STL_MAX : m_stall + 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge ap_clk) begin
    if (m_valid) begin
      checks++;
      if (block !== m_block) begin
        errors++; $display("FAIL model_block: got %b expected %b at %0t", block, m_block, $time);
      end
      checks++;
      if (block_pulse !== m_pulse) begin
        errors++; $display("FAIL model_pulse: got %b expected %b at %0t", block_pulse, m_pulse, $time);
      end
      checks++;
      if (block_mask !== m_mask) begin
        errors++; $display("FAIL model_mask: got %b expected %b at %0t", block_mask, m_mask, $time);
      end
      checks++;
      if (stall_cycles !== 16'(m_stall)) begin
        errors++; $display("FAIL model_stall: got %0d expected %0d at %0t", stall_cycles, m_stall, $time);
      end
      checks++;
      if (event_count !== 8'(m_evt)) begin
        errors++; $display("FAIL model_evt: got %0d expected %0d at %0t", event_count, m_evt, $time);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  task automatic drive(input logic [NCH-1:0] blk, input logic [NCH-1:0] idle, input logic iblk);
    axis_block_sigs = blk;
    inst_idle_sigs  = idle;
    inst_block_sigs = iblk;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    ap_rst_n = 1'b0; enable = 1'b0; clear = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0);
    step(2);
    chk("rst_block", int'(block), 0);
    chk("rst_evt", int'(event_count), 0);
    chk("rst_stall", int'(stall_cycles), 0);
    ap_rst_n = 1'b1; enable = 1'b1;

    // Basic declaration and latency
    drive(4'b0110, 4'b1001, 1'b0);
    step(7);
    chk("t1_block_pre", int'(block), 0);
    step(1);
    chk("t1_block", int'(block), 1);
    chk("t1_pulse", int'(block_pulse), 1);
    chk("t1_mask", int'(block_mask), 6);
    chk("t1_evt", int'(event_count), 1);
    chk("t1_stall8", int'(stall_cycles), 8);
    step(1);
    chk("t1_pulse_off", int'(block_pulse), 0);
    chk("t1_stall9", int'(stall_cycles), 9);
    step(1);
    chk("t1_stall10", int'(stall_cycles), 10);

    // Progress ends the episode; sticky values hold; second episode counts
    drive(4'b0000, 4'b0000, 1'b0);
    step(1);
    chk("t3_block_fall", int'(block), 0);
    chk("t3_mask_hold", int'(block_mask), 6);
    chk("t3_stall_hold", int'(stall_cycles), 10);
    drive(4'b0110, 4'b1001, 1'b0);
    step(8);
    chk("t3_block2", int'(block), 1);
    chk("t3_evt2", int'(event_count), 2);

    // Clear while blocked
    step(2);
    chk("t4_stall_pre", int'(stall_cycles), 10);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("t4_block", int'(block), 1);
    chk("t4_mask", int'(block_mask), 0);
    chk("t4_evt", int'(event_count), 0);
    chk("t4_stall0", int'(stall_cycles), 0);
    step(1);
    chk("t4_stall1", int'(stall_cycles), 1);

    // One-cycle break restarts the qualification count
    drive(4'b0000, 4'b0000, 1'b0);
    step(1);
    drive(4'b0110, 4'b1001, 1'b0);
    step(4);
    drive(4'b0100, 4'b1001, 1'b0);
    step(1);
    drive(4'b0110, 4'b1001, 1'b0);
    step(7);
    chk("t2_block_pre", int'(block), 0);
    chk("t2_evt_pre", int'(event_count), 0);
    step(1);
    chk("t2_block", int'(block), 1);
    chk("t2_evt", int'(event_count), 1);

    // Non-AXIS instance block with all channels idle, then reset mid-episode
    drive(4'b0000, 4'b0000, 1'b0);
    step(1);
    drive(4'b0000, 4'b1111, 1'b1);
    step(8);
    chk("t5_block", int'(block), 1);
    chk("t5_mask", int'(block_mask), 0);
    chk("t5_evt", int'(event_count), 2);
    step(2);
    ap_rst_n = 1'b0;
    step(1);
    ap_rst_n = 1'b1;
    chk("t5_rst_block", int'(block), 0);
    chk("t5_rst_stall", int'(stall_cycles), 0);
    chk("t5_rst_evt", int'(event_count), 0);
    drive(4'b0101, 4'b1111, 1'b0);
    step(10);
    chk("t5_allidle", int'(block), 0);

    // Disabled watchdog, then enable, then event saturation
    enable = 1'b0;
    drive(4'b0110, 4'b1001, 1'b0);
    step(20);
    chk("t6_disabled", int'(block), 0);
    enable = 1'b1;
    step(7);
    chk("t6_block_pre", int'(block), 0);
    step(1);
    chk("t6_block", int'(block), 1);
    chk("t6_evt1", int'(event_count), 1);
    for (int e = 0; e < 260; e++) begin
      drive(4'b0000, 4'b0000, 1'b0);
      step(1);
      drive(4'b0110, 4'b1001, 1'b0);
      step(8);
    end
    chk("t6_evt_sat", int'(event_count), 255);

    // Clear on the entry edge: entry values win
    drive(4'b0000, 4'b0000, 1'b0);
    step(1);
    drive(4'b0011, 4'b1100, 1'b0);
    step(7);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("t7_block", int'(block), 1);
    chk("t7_mask", int'(block_mask), 3);
    chk("t7_stall", int'(stall_cycles), 8);
    chk("t7_evt", int'(event_count), 1);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
